// File: rtl/sw_loader_pkg.sv
// ---------------------------------------------------------------------------
// sw_loader_pkg
//
// Shared definitions for the search-window fill path of the rotating UW/SW
// motion-estimation datapath.
//
// Contents:
//   SW_DEPTH_WORDS : words in the search-window RAM (352 bytes / 4)
//   SW_AW          : word address width
//   SW_LW          : burst length width
//   state_t        : loader FSM states (IDLE, LOAD, DONE)
//   sw_pack_word() : maps a fetched 32-bit word onto the RAM data lanes
//
// Configuration macro:
//   SW_LOADER_BSWAP_EN : when defined, sw_pack_word() reverses byte order
//                        for big-endian fetch sources; otherwise pass-through.
// ---------------------------------------------------------------------------
package sw_loader_pkg;

    localparam int SW_DEPTH_WORDS = 88;
    localparam int SW_AW          = 9;
    localparam int SW_LW          = 9;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    // Byte 0 of the RAM word is always the leftmost search-window column.
    function automatic logic [31:0] sw_pack_word(input logic [31:0] word);
`ifdef SW_LOADER_BSWAP_EN
        return {word[7:0], word[15:8], word[23:16], word[31:24]};
`else
        return word;
`endif
    endfunction

endpackage : sw_loader_pkg

// File: rtl/sw_word_loader_addr_wrap.sv
// ---------------------------------------------------------------------------
// sw_addr_wrap
//
// Combinational circular increment of a word address modulo DEPTH_WORDS.
// Shared with the read-side address generator so that both ends of the
// search-window RAM agree on where the window wraps.
//
// Parameters:
//   DEPTH_WORDS : modulus of the circular address space
//   AW          : address width
//
// Ports:
//   addr      in   AW  current address, assumed < DEPTH_WORDS
//   addr_next out  AW  addr + 1, or 0 when addr is the last word
// ---------------------------------------------------------------------------
module sw_addr_wrap
    import sw_loader_pkg::*;
#(
    parameter int DEPTH_WORDS = SW_DEPTH_WORDS,
    parameter int AW          = SW_AW
) (
    input  logic [AW-1:0] addr,
    output logic [AW-1:0] addr_next
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH_WORDS - 1);
    localparam logic [AW-1:0] ADDR_ONE  = AW'(1);

    assign addr_next = (addr == LAST_ADDR) ? '0 : addr + ADDR_ONE;

endmodule : sw_addr_wrap

// File: rtl/sw_word_loader.sv
// ---------------------------------------------------------------------------
// sw_word_loader
//
// Fill stage for the 4-column search-window register file. Accepts 32-bit
// pixel words (one search-window row each) over a valid/ready handshake and
// produces a registered write strobe, word address and data for the
// search-window RAM. Addresses advance circularly over the RAM depth so the
// window can be refreshed in rotating fashion; the write pointer persists
// across bursts so a burst may simply continue where the last one ended.
//
// Parameters:
//   DEPTH_WORDS : words in the search-window RAM
//   AW          : word address width
//   LW          : burst length width
//
// Ports:
//   clk        in   1   rising-edge clock
//   rst_n      in   1   asynchronous active-low reset
//   start      in   1   burst request, sampled only while idle
//   cont       in   1   1 = continue at wr_ptr, 0 = begin at start_addr
//   start_addr in   AW  first word address when cont=0
//   len        in   LW  words in the burst (0 allowed)
//   in_valid   in   1   source word valid
//   in_ready   out  1   loader accepts a word this cycle
//   in_data    in   32  pixel word, byte 0 = leftmost column
//   sw_we      out  1   RAM write strobe (one pulse per accepted word)
//   sw_addr    out  AW  RAM word address
//   sw_data    out  32  RAM write data
//   busy       out  1   burst in progress
//   done       out  1   one-cycle pulse after the last write of a burst
//   err        out  1   one-cycle pulse on a start with out-of-range address
//   wr_ptr     out  AW  next circular write address
//
// Configuration macro:
//   SW_LOADER_BSWAP_EN : byte-reverse each word for big-endian fetch sources.
// ---------------------------------------------------------------------------
module sw_word_loader
    import sw_loader_pkg::*;
#(
    parameter int DEPTH_WORDS = SW_DEPTH_WORDS,
    parameter int AW          = SW_AW,
    parameter int LW          = SW_LW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          cont,
    input  logic [AW-1:0] start_addr,
    input  logic [LW-1:0] len,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [31:0]   in_data,
    output logic          sw_we,
    output logic [AW-1:0] sw_addr,
    output logic [31:0]   sw_data,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [AW-1:0] wr_ptr
);

    localparam logic [AW-1:0] DEPTH_ADDR = AW'(DEPTH_WORDS);
    localparam logic [LW-1:0] CNT_ONE    = LW'(1);

    state_t        state_q, state_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic [LW-1:0] cnt_q, cnt_d;
    logic          sw_we_q, sw_we_d;
    logic [AW-1:0] sw_addr_q, sw_addr_d;
    logic [31:0]   sw_data_q, sw_data_d;
    logic          err_q, err_d;
    logic [AW-1:0] ptr_next;

    sw_addr_wrap #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_addr_wrap (
        .addr      (ptr_q),
        .addr_next (ptr_next)
    );

    // A zero-length burst sits in LOAD with cnt=0 for one cycle and must
    // never advertise ready, so ready also depends on the remaining count.
    assign in_ready = (state_q == LOAD) && (cnt_q != '0);

    always_comb begin
        // NOTE: every signal assigned below gets a default first, so no path
        // through the case leaves it unassigned and no latch is inferred.
        state_d   = state_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        sw_we_d   = 1'b0;
        sw_addr_d = sw_addr_q;
        sw_data_d = sw_data_q;
        err_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (cont) begin
                        cnt_d   = len;
                        state_d = LOAD;
                    end else if (start_addr < DEPTH_ADDR) begin
                        ptr_d   = start_addr;
                        cnt_d   = len;
                        state_d = LOAD;
                    end else begin
                        // Out-of-range address: reject, keep the pointer.
                        err_d = 1'b1;
                    end
                end
            end

            LOAD: begin
                if (cnt_q == '0) begin
                    state_d = DONE;
                end else if (in_valid) begin
                    sw_we_d   = 1'b1;
                    sw_addr_d = ptr_q;
                    sw_data_d = sw_pack_word(in_data);
                    ptr_d     = ptr_next;
                    cnt_d     = cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE) begin
                        state_d = DONE;
                    end
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its _d value from before the edge, independent of block order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            cnt_q     <= '0;
            sw_we_q   <= 1'b0;
            sw_addr_q <= '0;
            sw_data_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            sw_we_q   <= sw_we_d;
            sw_addr_q <= sw_addr_d;
            sw_data_q <= sw_data_d;
            err_q     <= err_d;
        end
    end

    assign sw_we   = sw_we_q;
    assign sw_addr = sw_addr_q;
    assign sw_data = sw_data_q;
    assign err     = err_q;
    assign wr_ptr  = ptr_q;
    assign busy    = (state_q != IDLE);
    // The last write is registered into the same cycle the FSM sits in DONE.
    assign done    = (state_q == DONE);

endmodule : sw_word_loader
